// File: rtl/aes_feed_ctrl.sv
// Sequencer that streams an expanded key and four plaintext words into an AES core,
// then waits (with timeout) for the ciphertext and presents it as a one-cycle pulse.
module aes_feed_ctrl #(
    parameter int NUM_KEY_WORDS  = 60,
    parameter int PREAMBLE_WORDS = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        key_rd_en,
    output logic [5:0]  key_rd_addr,
    input  logic [31:0] key_rd_data,
    input  logic        pt_valid,
    input  logic [31:0] pt_data,
    output logic        pt_ready,
    output logic        expandedKeyEnable,
    output logic [31:0] expandedKey,
    output logic        plaintextEnable,
    output logic [31:0] plaintext,
    input  logic        ciphertextDone,
    input  logic [31:0] ciphertext,
    output logic        ct_valid,
    output logic [31:0] ct_data,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, PRE, KEY, PT, WAIT, RESULT} state_t;

    localparam logic [2:0] PRE_LAST  = 3'(PREAMBLE_WORDS - 1);
    localparam logic [5:0] KEY_LAST  = 6'(NUM_KEY_WORDS - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [2:0]  pre_cnt;
    logic [5:0]  key_addr;
    logic [2:0]  pt_cnt;
    logic [7:0]  wait_cnt;
    logic        pt_xfer;
    logic        start_acc;
    logic        timeout_hit;
    logic        ct_take;
    logic        ek_en_p1;
    logic        key_vld_p1;
    logic        pt_en_p1;
    logic [31:0] pt_data_p1;
    logic        ct_valid_p1;
    logic [31:0] ct_data_p1;
    logic        timeout_q;

    assign busy        = (state != IDLE);
    assign key_rd_en   = (state == KEY);
    assign key_rd_addr = key_addr;
    assign pt_ready    = (state == PT);
    assign pt_xfer     = pt_valid && pt_ready;
    assign start_acc   = (state == IDLE) && start && !abort;
    assign ct_take     = (state == WAIT) && ciphertextDone && !abort;
    // The result wins over a timeout landing in the same cycle.
    assign timeout_hit = (state == WAIT) && !ciphertextDone && (wait_cnt == WAIT_LAST) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (PREAMBLE_WORDS == 0) ? KEY : PRE;
            PRE:     if (pre_cnt == PRE_LAST) state_n = KEY;
            KEY:     if (key_addr == KEY_LAST) state_n = PT;
            PT:      if (pt_xfer && (pt_cnt == 3'd3)) state_n = WAIT;
            WAIT: begin
                if (ciphertextDone)              state_n = RESULT;
                else if (wait_cnt == WAIT_LAST)  state_n = IDLE;
            end
            RESULT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    // Each counter runs only while its state persists and is cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            key_addr <= '0;
            pt_cnt   <= '0;
            wait_cnt <= '0;
        end else begin
            pre_cnt  <= (state == PRE  && state_n == PRE)  ? pre_cnt + 3'd1  : 3'd0;
            key_addr <= (state == KEY  && state_n == KEY)  ? key_addr + 6'd1 : 6'd0;
            wait_cnt <= (state == WAIT && state_n == WAIT) ? wait_cnt + 8'd1 : 8'd0;
            pt_cnt   <= (state == PT   && state_n == PT)   ? pt_cnt + (pt_xfer ? 3'd1 : 3'd0) : 3'd0;
        end
    end

    // Stage p1: registered core-facing strobes; RAM data arrives alongside key_vld_p1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ek_en_p1    <= 1'b0;
            key_vld_p1  <= 1'b0;
            pt_en_p1    <= 1'b0;
            pt_data_p1  <= '0;
            ct_valid_p1 <= 1'b0;
            ct_data_p1  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            ek_en_p1    <= (state_n == PRE) || (key_rd_en && !abort);
            key_vld_p1  <= key_rd_en && !abort;
            pt_en_p1    <= pt_xfer && !abort;
            ct_valid_p1 <= ct_take;
            if (pt_xfer) pt_data_p1 <= pt_data;
            if (ct_take) ct_data_p1 <= ciphertext;
            if (start_acc)        timeout_q <= 1'b0;
            else if (timeout_hit) timeout_q <= 1'b1;
        end
    end

    assign expandedKeyEnable = ek_en_p1;
    assign expandedKey       = key_vld_p1 ? key_rd_data : 32'd0;
    assign plaintextEnable   = pt_en_p1;
    assign plaintext         = pt_data_p1;
    assign ct_valid          = ct_valid_p1;
    assign ct_data           = ct_data_p1;
    assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_aes_feed_ctrl.sv
// Directed bench for aes_feed_ctrl: key stream, plaintext handshake, result, timeout,
// abort, asynchronous reset and start-while-busy.
module tb_aes_feed_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic        busy, key_rd_en;
    logic [5:0]  key_rd_addr;
    logic [31:0] key_rd_data;
    logic        pt_valid, pt_ready;
    logic [31:0] pt_data;
    logic        expandedKeyEnable, plaintextEnable, ciphertextDone, ct_valid, timeout_err;
    logic [31:0] expandedKey, plaintext, ciphertext, ct_data;

    int tests = 0;
    int fails = 0;

    aes_feed_ctrl #(.NUM_KEY_WORDS(60), .PREAMBLE_WORDS(4), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
        .key_rd_en(key_rd_en), .key_rd_addr(key_rd_addr), .key_rd_data(key_rd_data),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
        .expandedKeyEnable(expandedKeyEnable), .expandedKey(expandedKey),
        .plaintextEnable(plaintextEnable), .plaintext(plaintext),
        .ciphertextDone(ciphertextDone), .ciphertext(ciphertext),
        .ct_valid(ct_valid), .ct_data(ct_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Key RAM: word i holds 0xA5000000+i, one-cycle read latency.
    always_ff @(posedge clk) key_rd_data <= 32'hA500_0000 + {26'd0, key_rd_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] pt_words [4];
    logic        pv_tab   [6];
    int          pw_tab   [6];
    logic        pe_exp   [7];
    int          pe_idx   [7];

    initial begin
        pt_words = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF};
        pv_tab   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pw_tab   = '{0, 1, 0, 0, 2, 3};
        pe_exp   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        pe_idx   = '{0, 0, 1, 0, 0, 2, 3};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pt_valid = 1'b0; pt_data = '0; ciphertextDone = 1'b0; ciphertext = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_key_rd_en", {31'd0, key_rd_en}, 32'd0);
        chk("rst_pt_ready", {31'd0, pt_ready}, 32'd0);
        chk("rst_strobes", {29'd0, expandedKeyEnable, plaintextEnable, ct_valid}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        chk("rst_addr", {26'd0, key_rd_addr}, 32'd0);
        chk("rst_ekey", expandedKey, 32'd0);
        chk("rst_pt", plaintext, 32'd0);
        chk("rst_ct", ct_data, 32'd0);
        rst = 1'b0;
        step();

        // Full sequence: start in cycle 0.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("pre_en", {31'd0, expandedKeyEnable}, 32'd1);
            chk("pre_data", expandedKey, 32'd0);
            step();
        end
        // Cycles 5..65: reads at 5..64, key words at 6..65.
        for (int c = 5; c <= 65; c++) begin
            if (c <= 64) begin
                chk("key_rd_en", {31'd0, key_rd_en}, 32'd1);
                chk("key_addr", {26'd0, key_rd_addr}, 32'(c - 5));
            end
            if (c >= 6) begin
                chk("key_en", {31'd0, expandedKeyEnable}, 32'd1);
                chk("key_data", expandedKey, 32'hA500_0000 + 32'(c - 6));
            end
            if (c < 65) step();
        end
        chk("pt_entry_ready", {31'd0, pt_ready}, 32'd1);

        // Plaintext with a 2-cycle gap between words 2 and 3.
        for (int k = 0; k < 6; k++) begin
            chk("pt_ready", {31'd0, pt_ready}, 32'd1);
            chk("pt_en", {31'd0, plaintextEnable}, {31'd0, pe_exp[k]});
            if (pe_exp[k]) chk("pt_data", plaintext, pt_words[pe_idx[k]]);
            pt_valid = pv_tab[k];
            pt_data  = pv_tab[k] ? pt_words[pw_tab[k]] : 32'h0;
            step();
        end
        pt_valid = 1'b0;
        chk("pt_en_last", {31'd0, plaintextEnable}, 32'd1);
        chk("pt_data_last", plaintext, pt_words[3]);
        chk("pt_ready_drop", {31'd0, pt_ready}, 32'd0);

        // Ciphertext 10 cycles into WAIT.
        for (int i = 0; i < 10; i++) begin
            chk("wait_busy", {31'd0, busy}, 32'd1);
            step();
        end
        ciphertextDone = 1'b1; ciphertext = 32'hDEAD_BEEF;
        step();
        ciphertextDone = 1'b0; ciphertext = '0;
        chk("ct_valid", {31'd0, ct_valid}, 32'd1);
        chk("ct_data", ct_data, 32'hDEAD_BEEF);
        step();
        chk("ct_valid_once", {31'd0, ct_valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);

        // Timeout: no ciphertextDone for 20 WAIT cycles.
        start = 1'b1;
        step();
        start = 1'b0;
        pt_valid = 1'b1;
        repeat (68) step();
        pt_valid = 1'b0;
        chk("to_wait_ready", {31'd0, pt_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("to_pending", {31'd0, timeout_err}, 32'd0);
            chk("to_busy", {31'd0, busy}, 32'd1);
            step();
        end
        chk("to_set", {31'd0, timeout_err}, 32'd1);
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_ct_kept", ct_data, 32'hDEAD_BEEF);

        // Abort overrides start in IDLE.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", {31'd0, busy}, 32'd0);
        chk("abort_start_to_kept", {31'd0, timeout_err}, 32'd1);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_clear", {31'd0, timeout_err}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);

        // Abort in KEY at address 30 (cycle 35).
        repeat (34) step();
        chk("abort_addr", {26'd0, key_rd_addr}, 32'd30);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_enables", {28'd0, key_rd_en, pt_ready, expandedKeyEnable, plaintextEnable}, 32'd0);
        chk("abort_ct_kept", ct_data, 32'hDEAD_BEEF);

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("reabort_addr0", {26'd0, key_rd_addr}, 32'd0);
        chk("reabort_rd_en", {31'd0, key_rd_en}, 32'd1);

        // Start while busy (cycle 20) must not restart.
        repeat (15) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_addr", {26'd0, key_rd_addr}, 32'd16);
        repeat (44) step();
        chk("busy_start_pt", {31'd0, pt_ready}, 32'd1);
        chk("busy_start_last_key", expandedKey, 32'hA500_003B);

        // Asynchronous reset during PT.
        #2 rst = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_enables", {27'd0, key_rd_en, pt_ready, expandedKeyEnable, plaintextEnable, ct_valid}, 32'd0);
        chk("async_ct", ct_data, 32'd0);
        chk("async_ekey", expandedKey, 32'd0);
        #1 rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_rst_pre_en", {31'd0, expandedKeyEnable}, 32'd1);
        chk("post_rst_pre_data", expandedKey, 32'd0);
        repeat (4) step();
        chk("post_rst_addr0", {26'd0, key_rd_addr}, 32'd0);

        // Done arrives in the same cycle as the timeout: result wins.
        pt_valid = 1'b1;
        repeat (64) step();
        pt_valid = 1'b0;
        repeat (19) step();
        ciphertextDone = 1'b1; ciphertext = 32'h1234_5678;
        step();
        ciphertextDone = 1'b0;
        chk("prio_ct_valid", {31'd0, ct_valid}, 32'd1);
        chk("prio_ct_data", ct_data, 32'h1234_5678);
        chk("prio_no_to", {31'd0, timeout_err}, 32'd0);
        step();
        chk("prio_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
